// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared datapath width, load funct3 encodings, the x0 register
//               index and the load-type enum used by the writeback stage and
//               the data-memory bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Integer datapath width; must match the register file.
  localparam int XLEN = 64;

  // Register index width and the hard-wired zero register.
  localparam int          REG_AW   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Load type as decoded from funct3; 3'b111 has no legal meaning.
  typedef enum logic [2:0] {
    LT_LB      = 3'b000,
    LT_LH      = 3'b001,
    LT_LW      = 3'b010,
    LT_LD      = 3'b011,
    LT_LBU     = 3'b100,
    LT_LHU     = 3'b101,
    LT_LWU     = 3'b110,
    LT_ILLEGAL = 3'b111
  } load_type_e;

  // True when funct3 names an implemented load.
  function automatic logic is_legal_load(input logic [2:0] funct3);
    return (funct3 != 3'b111);
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/regfile_writeback_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Purely combinational load-data formatter. Selects the byte,
//               halfword, word or doubleword addressed by ld_offset inside an
//               aligned doubleword and sign- or zero-extends it to XLEN.
//               Shared with the data-memory bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  output logic [XLEN-1:0] ext_data,
  output logic            ext_legal
);

  import riscv_pkg::*;

  // Field candidates, each shifted down so the addressed field sits at bit 0.
  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [XLEN-1:0] word_shift;
  logic [7:0]      byte_fld;
  logic [15:0]     half_fld;
  logic [31:0]     word_fld;
  load_type_e      ltype;

  // Offset alignment: halfwords drop offset[0], words drop offset[1:0].
  always_comb begin
    byte_shift = ld_data >> {ld_offset, 3'b000};
    half_shift = ld_data >> {ld_offset[2:1], 4'b0000};
    word_shift = ld_data >> {ld_offset[2], 5'b00000};
    byte_fld   = byte_shift[7:0];
    half_fld   = half_shift[15:0];
    word_fld   = word_shift[31:0];
  end

  // Type decode and extension; illegal encodings produce zero and flag it.
  always_comb begin
    ltype     = load_type_e'(ld_funct3);
    ext_legal = is_legal_load(ld_funct3);
    ext_data  = '0;
    case (ltype)
      LT_LB:   ext_data = {{(XLEN-8){byte_fld[7]}}, byte_fld};
      LT_LH:   ext_data = {{(XLEN-16){half_fld[15]}}, half_fld};
      LT_LW:   ext_data = {{(XLEN-32){word_fld[31]}}, word_fld};
      LT_LD:   ext_data = ld_data;
      LT_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_fld};
      LT_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_fld};
      LT_LWU:  ext_data = {{(XLEN-32){1'b0}}, word_fld};
      default: ext_data = '0;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Writeback stage driving the single register-file write port.
//               Arbitrates ALU and load results (load priority with an ALU
//               starvation guard), formats load data, suppresses x0 writes
//               and presents each write for exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  output logic            RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] WriteData,
  output logic            wb_busy
);

  import riscv_pkg::*;

  localparam int                SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     SAT_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic            alu_forced;
  logic            alu_hs;
  logic            ld_hs;
  logic [XLEN-1:0] ld_ext;
  logic            ld_legal;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .ld_data   (ld_data),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .ext_data  (ld_ext),
    .ext_legal (ld_legal)
  );

  // Arbitration: load wins conflicts unless the ALU has been starved too long.
  always_comb begin
    alu_forced = (starve_q == SAT_MAX);
    ld_ready   = ~reset & ld_valid & ~(alu_valid & alu_forced);
    alu_ready  = ~reset & alu_valid & (~ld_valid | alu_forced);
    alu_hs     = alu_ready;
    ld_hs      = ld_ready;
  end

  // Starvation counter: count lost conflicts, saturate, clear on ALU win or idle.
  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_hs) begin
      starve_d = '0;
    end else if (ld_hs && (starve_q != SAT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Next write: at most one source per cycle; x0 and illegal loads leave RD/data untouched.
  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (alu_hs && (alu_rd != REG_ZERO)) begin
      we_d = 1'b1;
      rd_d = alu_rd;
      wd_d = alu_data;
    end else if (ld_hs && ld_legal && (ld_rd != REG_ZERO)) begin
      we_d = 1'b1;
      rd_d = ld_rd;
      wd_d = ld_ext;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  // Outputs come from flops; reset also blanks a result already registered so it is never committed.
  always_comb begin
    RegWrite  = we_q & ~reset;
    RD        = reset ? REG_ZERO : rd_q;
    WriteData = reset ? '0 : wd_q;
    wb_busy   = RegWrite;
  end

endmodule : regfile_writeback
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Directed self-checking bench for regfile_writeback with a
//               scoreboard of expected writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  import riscv_pkg::*;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_funct3, ld_offset;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic        wb_busy;

  always #5 clk = ~clk;

  regfile_writeback #(
    .XLEN         (64),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData),
    .wb_busy   (wb_busy)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wd;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          starve_m = 0;
  logic [4:0]  hold_rd = '0;
  logic [63:0] hold_wd = '0;
  logic        ld_exp_we;
  logic [63:0] ld_exp_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the scoreboard, compare readies
  // against the arbitration model, then record what this cycle should write.
  task automatic cycle(input string tag);
    exp_t        e;
    logic        ld_win, alu_win;
    logic [4:0]  exp_rd;
    logic [63:0] exp_wd;
    @(negedge clk);
    if (reset) begin
      chk({tag, "/RegWrite"}, 64'(RegWrite), 64'd0);
      chk({tag, "/RD"}, 64'(RD), 64'd0);
      chk({tag, "/WriteData"}, WriteData, 64'd0);
      chk({tag, "/alu_ready"}, 64'(alu_ready), 64'd0);
      chk({tag, "/ld_ready"}, 64'(ld_ready), 64'd0);
      sb.delete();
      hold_rd  = '0;
      hold_wd  = '0;
      starve_m = 0;
    end else begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{we: 1'b0, rd: 5'd0, wd: 64'd0};
      if (e.we) begin
        hold_rd = e.rd;
        hold_wd = e.wd;
      end
      exp_rd = hold_rd;
      exp_wd = hold_wd;
      chk({tag, "/RegWrite"}, 64'(RegWrite), 64'(e.we));
      chk({tag, "/wb_busy"}, 64'(wb_busy), 64'(e.we));
      chk({tag, "/RD"}, 64'(RD), 64'(exp_rd));
      chk({tag, "/WriteData"}, WriteData, exp_wd);
      ld_win  = ld_valid && !(alu_valid && starve_m == LIMIT);
      alu_win = alu_valid && !ld_win;
      chk({tag, "/alu_ready"}, 64'(alu_ready), 64'(alu_win));
      chk({tag, "/ld_ready"}, 64'(ld_ready), 64'(ld_win));
      if (!alu_valid || alu_win) starve_m = 0;
      else if (starve_m < LIMIT) starve_m++;
      if (alu_win) sb.push_back('{we: (alu_rd != 5'd0), rd: alu_rd, wd: alu_data});
      else if (ld_win) sb.push_back('{we: ld_exp_we, rd: ld_rd, wd: ld_exp_wd});
      else sb.push_back('{we: 1'b0, rd: 5'd0, wd: 64'd0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [63:0] data, input logic [2:0] f3,
                        input logic [2:0] off, input logic exp_we, input logic [63:0] exp_wd);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_data   = data;
    ld_funct3 = f3;
    ld_offset = off;
    ld_exp_we = exp_we;
    ld_exp_wd = exp_wd;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [63:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; ld_funct3 = '0; ld_offset = '0;
    ld_exp_we = 1'b0; ld_exp_wd = '0;

    // Reset state
    cycle("reset0");
    cycle("reset1");
    reset = 1'b0;
    cycle("post_reset");

    // ALU only: write in N+1 only
    set_alu(5'd5, 64'h1234);
    cycle("alu_hs");
    idle();
    cycle("alu_wr");
    cycle("alu_gone");

    // Load extension, back-to-back
    set_ld(5'd7, 64'h0000_0000_0000_F080, F3_LB, 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    cycle("lb");
    set_ld(5'd7, 64'h0000_0000_0000_F080, F3_LBU, 3'd1, 1'b1, 64'h0000_0000_0000_00F0);
    cycle("lbu");
    set_ld(5'd8, 64'h8000_0001_0000_0000, F3_LW, 3'd4, 1'b1, 64'hFFFF_FFFF_8000_0001);
    cycle("lw");
    set_ld(5'd11, 64'h0000_0000_8001_0000, F3_LH, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
    cycle("lh");
    set_ld(5'd12, 64'h0000_0000_8001_0000, F3_LHU, 3'd2, 1'b1, 64'h0000_0000_0000_8001);
    cycle("lhu");
    set_ld(5'd13, 64'h8000_0001_0000_0000, F3_LWU, 3'd5, 1'b1, 64'h0000_0000_8000_0001);
    cycle("lwu");
    idle();
    cycle("ext_drain");

    // Contention: loads win 1-3, ALU forced on 4, load on 5
    set_alu(5'd3, 64'h3333);
    for (int i = 0; i < 5; i++) begin
      set_ld(5'(10 + i), 64'h1111_0000_0000_0000 + 64'(i), F3_LD, 3'd0, 1'b1,
             64'h1111_0000_0000_0000 + 64'(i));
      cycle("contend");
    end
    idle();
    cycle("contend_drain");

    // x0 from the ALU: consumed, no write, RD/WriteData held
    set_alu(5'd0, 64'hDEAD);
    cycle("x0_hs");
    idle();
    cycle("x0_nowrite");

    // Illegal funct3 then a full LD to the same register
    set_ld(5'd9, 64'h1234_5678_9ABC_DEF0, 3'b111, 3'd0, 1'b0, 64'd0);
    cycle("illegal_hs");
    set_ld(5'd9, 64'hAAAA_BBBB_CCCC_DDDD, F3_LD, 3'd6, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    cycle("ld_full");
    idle();
    cycle("ld_full_wr");

    // Reset right after a handshake drops the pending result
    set_alu(5'd4, 64'h4444);
    cycle("rst_hs");
    idle();
    reset = 1'b1;
    cycle("rst_mid");
    reset = 1'b0;
    cycle("rst_after");
    cycle("rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_writeback
`default_nettype wire
